seq_math_unit: RTL
==================

Name: seq_math_unit

Overview:
- Parametrised, registered arithmetic unit for WIDTH-bit operands.
- Operations: ADD, SUB (two's complement), unsigned multi-cycle shift-add MUL, and status flags.
- Uses a start/busy/done handshake, so a top-level FSM can issue one operation at a time and read held results.
- Sits between switch/operand registers and display/decode logic in lab top levels. Replaces purely combinational add/sub blocks.

Parameters:
- WIDTH, 4, operand width in bits. Legal range is 2..16.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request an operation; sampled only in IDLE
- op  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 reserved (treated as ADD)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  operation in progress
- done  out  1  single-cycle pulse when result/flags update
- result  out  2*WIDTH  ADD/SUB: zero-extended WIDTH-bit result; MUL: full unsigned product
- carry  out  1  ADD: carry out; SUB: no-borrow (1 when a >= b unsigned); MUL: 0
- ovf  out  1  ADD/SUB: signed overflow; MUL: 0
- zero  out  1  result == 0
- neg  out  1  ADD/SUB: result[WIDTH-1]; MUL: 0

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low (rst_n). All state changes occur on rising clk.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - result = 0
  - carry = 0, ovf = 0, neg = 0
  - zero = 1
- States: IDLE, ARITH, MUL, DONE.
- IDLE:
  - If start = 1 at edge N: latch a, b, op internally; set busy = 1.
  - op 00/01/11 -> ARITH.
  - op 10 -> MUL; load multiplicand, multiplier, product = 0, count = 0.
- ARITH (one cycle):
  - SUB computes a + ~b + 1 through the same ripple adder (b inverted, carry-in = 1).
  - At edge N+1: register result and flags, busy = 0, done = 1, -> DONE.
- MUL (WIDTH cycles):
  - Each edge: if multiplier[0], product += multiplicand << count. Multiplier shifts right, count increments.
  - At the edge after the final iteration (edge N+WIDTH), register product and flags, busy = 0, done = 1, -> DONE.
- Latency from the start edge to done high: ADD/SUB = 1 cycle; MUL = WIDTH cycles.
- DONE: done = 0 at the next edge, -> IDLE. A start sampled in DONE is ignored.
- Outputs result/flags hold their last values until the next operation completes; they do not change while busy.
- start is ignored while busy = 1 or in DONE. Operand changes on a/b while busy have no effect, because latched copies are used.
- ovf (ADD) = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
- ovf (SUB) = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
- All arithmetic wraps modulo 2^WIDTH (ADD/SUB) or 2^(2*WIDTH) (MUL, which cannot overflow).
- Reset mid-operation: rst_n = 0 at any edge forces the reset values above. No done pulse is produced for the aborted operation.
- start and rst_n both active at the same edge: reset wins.

Decomposition:
- Shared package math_pkg:
  - opcode constants OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10
  - state encoding constants ST_IDLE, ST_ARITH, ST_MUL, ST_DONE
- One sub-module, ripple_adder_n:
  - Parametrised WIDTH-bit ripple-carry adder with cin, cout, and MSB carry-in (for the ovf cross-check).
  - Instantiated once for ADD/SUB and once for the MUL accumulate step (2*WIDTH wide).

Test Plan (WIDTH = 4):
- ADD a=7, b=9, start one cycle -> after 1 cycle done=1 for exactly one cycle; result=0x00, carry=1, zero=1, ovf=0, neg=0.
- SUB a=3, b=5 -> result=0x0E, carry=0, neg=1, ovf=0, zero=0. SUB a=8, b=1 -> result=0x07, ovf=1, carry=1.
- MUL a=15, b=15 -> busy high 4 cycles, done on cycle 4 after start; result=0xE1, carry=0, ovf=0, zero=0. MUL a=0, b=9 -> result=0x00, zero=1.
- Second start (ADD 1+1) asserted on cycle 2 of a running MUL 3*5, with a/b changed -> ignored; result=0x0F; exactly one done pulse.
- rst_n=0 on cycle 2 of MUL 6*7 -> next edge busy=0, result=0, zero=1, no done pulse. Fresh ADD 2+2 afterwards -> result=0x04.
- start held high continuously with ADD 1+2 -> one operation per three cycles (IDLE->ARITH->DONE); done pulses every third cycle; result stays 0x03.

Source files
------------

// File: rtl/math_pkg.sv
// Shared opcode and FSM state definitions for the sequential math unit.
package math_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARITH = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ripple_adder_n.sv
// Parametrised ripple-carry adder; also exposes the carry into the MSB
// so the caller can derive signed overflow as cout ^ cmsb.
module ripple_adder_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic carry;

    // Walk the carry from LSB to MSB one full-adder cell at a time.
    always_comb begin
        sum_o  = '0;
        cmsb_o = 1'b0;
        carry  = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                cmsb_o = carry;
            end
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (a_i[i] & carry) | (b_i[i] & carry);
        end
        cout_o = carry;
    end

endmodule

// File: rtl/seq_math_unit.sv
// Registered ADD/SUB/MUL unit with a start/busy/done handshake.
// Results and flags are held until the next operation completes.
module seq_math_unit
    import math_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 ovf,
    output logic                 zero,
    output logic                 neg
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [PW-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [PW-1:0]   product_q, product_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   result_q, result_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;

    logic             isSub;
    logic [WIDTH-1:0] arithB;
    logic [WIDTH-1:0] arithSum;
    logic             arithCout;
    logic             arithCmsb;
    logic [PW-1:0]    mulAddend;
    logic [PW-1:0]    mulSum;
    logic             unusedMulCout;
    logic             unusedMulCmsb;

    // SUB reuses the adder as a + ~b + 1; reserved opcode falls through as ADD.
    assign isSub  = (op_q == OP_SUB);
    assign arithB = isSub ? ~opB_q : opB_q;

    ripple_adder_n #(.WIDTH(WIDTH)) uArithAdder (
        .a_i    (opA_q[WIDTH-1:0]),
        .b_i    (arithB),
        .cin_i  (isSub),
        .sum_o  (arithSum),
        .cout_o (arithCout),
        .cmsb_o (arithCmsb)
    );

    // The multiplicand register is shifted left each step, so it already
    // equals multiplicand << count when it is added.
    assign mulAddend = opB_q[0] ? opA_q : '0;

    ripple_adder_n #(.WIDTH(PW)) uMulAdder (
        .a_i    (product_q),
        .b_i    (mulAddend),
        .cin_i  (1'b0),
        .sum_o  (mulSum),
        .cout_o (unusedMulCout),
        .cmsb_o (unusedMulCmsb)
    );

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        product_d = product_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    opA_d     = {{WIDTH{1'b0}}, a};
                    opB_d     = b;
                    product_d = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = (op == OP_MUL) ? ST_MUL : ST_ARITH;
                end
            end
            ST_ARITH: begin
                result_d = {{WIDTH{1'b0}}, arithSum};
                carry_d  = arithCout;
                ovf_d    = arithCout ^ arithCmsb;
                neg_d    = arithSum[WIDTH-1];
                zero_d   = (arithSum == '0);
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_MUL: begin
                product_d = mulSum;
                opA_d     = opA_q << 1;
                opB_d     = opB_q >> 1;
                count_d   = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    result_d = mulSum;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    neg_d    = 1'b0;
                    zero_d   = (mulSum == '0);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            opA_q     <= '0;
            opB_q     <= '0;
            product_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            product_q <= product_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
    assign neg    = neg_q;

endmodule
